// File: rtl/maq_venda_param.sv
// Parameterised vending machine: coin credit, product selection, one-cycle
// dispense and greedy coin-by-coin change refund.
module maq_venda_param #(
  parameter int N_PROD     = 4,
  parameter int PRICE_BASE = 20,
  parameter int PRICE_STEP = 5,
  parameter int MAX_CREDIT = 100,
  parameter int CRED_W     = 8,
  localparam int SEL_W     = (N_PROD > 2) ? $clog2(N_PROD) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        coin,
  input  logic [SEL_W-1:0]  sel,
  input  logic              sel_valid,
  input  logic              cancel,
  output logic [CRED_W-1:0] credit,
  output logic              dispense,
  output logic [SEL_W-1:0]  disp_id,
  output logic              change_valid,
  output logic [1:0]        change_coin,
  output logic              coin_reject,
  output logic              deny
);

  typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;

  state_t            state, state_n;
  logic [CRED_W-1:0] credit_n;
  logic [SEL_W-1:0]  sel_q, sel_n;
  logic [1:0]        coin_prev;
  logic              rej_n, deny_n;
  logic              coin_evt, sel_ok, busy;
  logic [31:0]       coin_val, price, cred32, chg_val;
  logic [1:0]        chg_code;

  assign coin_evt = (coin_prev == 2'b00) && (coin != 2'b00);
  assign cred32   = 32'(credit);
  assign price    = 32'(PRICE_BASE) + 32'(sel) * 32'(PRICE_STEP);
  assign sel_ok   = (32'(sel) < 32'(N_PROD)) && (cred32 >= price);

  always_comb begin
    case (coin)
      2'b01:   coin_val = 32'd5;
      2'b10:   coin_val = 32'd10;
      2'b11:   coin_val = 32'd25;
      default: coin_val = 32'd0;
    endcase
  end

  always_comb begin
    if (cred32 >= 32'd25) begin
      chg_val  = 32'd25;
      chg_code = 2'b11;
    end else if (cred32 >= 32'd10) begin
      chg_val  = 32'd10;
      chg_code = 2'b10;
    end else begin
      chg_val  = 32'd5;
      chg_code = 2'b01;
    end
  end

  // A request (cancel or sel_valid) owns the cycle; a coin arriving with it is returned.
  assign busy = cancel || sel_valid;

  always_comb begin
    state_n  = state;
    credit_n = credit;
    sel_n    = sel_q;
    rej_n    = 1'b0;
    deny_n   = 1'b0;
    case (state)
      IDLE, CREDIT: begin
        if (cancel) begin
          if (state == CREDIT) state_n = CHANGE;
        end else if (sel_valid) begin
          if (sel_ok) begin
            credit_n = CRED_W'(cred32 - price);
            sel_n    = sel;
            state_n  = DISPENSE;
          end else begin
            deny_n = 1'b1;
          end
        end
        if (coin_evt) begin
          if (busy || (cred32 + coin_val > 32'(MAX_CREDIT))) begin
            rej_n = 1'b1;
          end else begin
            credit_n = CRED_W'(cred32 + coin_val);
            state_n  = CREDIT;
          end
        end
      end
      DISPENSE: begin
        rej_n   = coin_evt;
        state_n = (credit == '0) ? IDLE : CHANGE;
      end
      CHANGE: begin
        rej_n = coin_evt;
        if (credit == '0) begin
          state_n = IDLE;
        end else begin
          credit_n = CRED_W'(cred32 - chg_val);
          if (cred32 == chg_val) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      credit      <= '0;
      sel_q       <= '0;
      coin_prev   <= '0;
      coin_reject <= 1'b0;
      deny        <= 1'b0;
    end else begin
      state       <= state_n;
      credit      <= credit_n;
      sel_q       <= sel_n;
      coin_prev   <= coin;
      coin_reject <= rej_n;
      deny        <= deny_n;
    end
  end

  always_comb begin
    dispense     = (state == DISPENSE);
    disp_id      = (state == DISPENSE) ? sel_q : '0;
    change_valid = (state == CHANGE) && (credit != '0);
    change_coin  = change_valid ? chg_code : 2'b00;
  end

endmodule

// File: tb/tb_maq_venda_param.sv
// Directed vector bench for maq_venda_param with default parameters.
module tb_maq_venda_param;

  logic       clk = 1'b0;
  logic       rst, sel_valid, cancel;
  logic [1:0] coin, sel;
  logic [7:0] credit;
  logic       dispense, change_valid, coin_reject, deny;
  logic [1:0] disp_id, change_coin;

  int checks = 0;
  int errors = 0;

  maq_venda_param #(
    .N_PROD(4), .PRICE_BASE(20), .PRICE_STEP(5), .MAX_CREDIT(100), .CRED_W(8)
  ) dut (
    .clk(clk), .rst(rst), .coin(coin), .sel(sel), .sel_valid(sel_valid),
    .cancel(cancel), .credit(credit), .dispense(dispense), .disp_id(disp_id),
    .change_valid(change_valid), .change_coin(change_coin),
    .coin_reject(coin_reject), .deny(deny)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rst, coin, sel, sv, cancel;
    int credit, disp, id, cv, cc, rej, deny;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int r, int c, int s, int sv, int cn,
                              int cr, int d, int id, int cv, int cc, int rj, int dn);
    vec_t v;
    v = '{r, c, s, sv, cn, cr, d, id, cv, cc, rj, dn};
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic step(input int r, input int c, input int s, input int sv, input int cn);
    rst       = r[0];
    coin      = c[1:0];
    sel       = s[1:0];
    sel_valid = sv[0];
    cancel    = cn[0];
    @(posedge clk);
    #1;
  endtask

  // Insert coins (each followed by an idle sample), buy product s, then
  // follow the refund against a greedy change model.
  task automatic buy_refund(input int c0, input int c1, input int c2, input int c3,
                            input int c4, input int s, input int tag);
    int codes[5];
    int total, rem, val, code;
    codes = '{c0, c1, c2, c3, c4};
    total = 0;
    foreach (codes[i]) begin
      if (codes[i] != 0) begin
        step(0, codes[i], 0, 0, 0);
        step(0, 0, 0, 0, 0);
        total += (codes[i] == 1) ? 5 : (codes[i] == 2) ? 10 : 25;
      end
    end
    chk("seq_credit", tag, int'(credit), total);
    rem = total - (20 + 5 * s);
    step(0, 0, s, 1, 0);
    chk("seq_dispense", tag, int'(dispense), 1);
    chk("seq_disp_id", tag, int'(disp_id), s);
    chk("seq_after_buy", tag, int'(credit), rem);
    step(0, 0, 0, 0, 0);
    while (rem > 0) begin
      val  = (rem >= 25) ? 25 : (rem >= 10) ? 10 : 5;
      code = (rem >= 25) ? 3 : (rem >= 10) ? 2 : 1;
      chk("seq_change_valid", tag, int'(change_valid), 1);
      chk("seq_change_coin", tag, int'(change_coin), code);
      chk("seq_change_credit", tag, int'(credit), rem);
      rem -= val;
      step(0, 0, 0, 0, 0);
    end
    chk("seq_end_valid", tag, int'(change_valid), 0);
    chk("seq_end_credit", tag, int'(credit), 0);
  endtask

  initial begin
    rst = 1'b1; coin = '0; sel = '0; sel_valid = 1'b0; cancel = 1'b0;

    // rst coin sel sv cancel | credit disp id cv cc rej deny
    add(1,0,0,0,0,   0,0,0,0,0,0,0);
    add(1,0,0,0,0,   0,0,0,0,0,0,0);
    // exact pay 10+10, product 0
    add(0,2,0,0,0,  10,0,0,0,0,0,0);
    add(0,0,0,0,0,  10,0,0,0,0,0,0);
    add(0,2,0,0,0,  20,0,0,0,0,0,0);
    add(0,0,0,1,0,   0,1,0,0,0,0,0);
    add(0,0,0,0,0,   0,0,0,0,0,0,0);
    // overpay 25+10, product 1 (25), change one 10
    add(0,3,0,0,0,  25,0,0,0,0,0,0);
    add(0,0,0,0,0,  25,0,0,0,0,0,0);
    add(0,2,0,0,0,  35,0,0,0,0,0,0);
    add(0,0,1,1,0,  10,1,1,0,0,0,0);
    add(0,0,0,0,0,  10,0,0,1,2,0,0);
    add(0,0,0,0,0,   0,0,0,0,0,0,0);
    // ceiling at 100, rejected 25, cancel refunds 4x25
    add(0,3,0,0,0,  25,0,0,0,0,0,0);
    add(0,0,0,0,0,  25,0,0,0,0,0,0);
    add(0,3,0,0,0,  50,0,0,0,0,0,0);
    add(0,0,0,0,0,  50,0,0,0,0,0,0);
    add(0,3,0,0,0,  75,0,0,0,0,0,0);
    add(0,0,0,0,0,  75,0,0,0,0,0,0);
    add(0,3,0,0,0, 100,0,0,0,0,0,0);
    add(0,0,0,0,0, 100,0,0,0,0,0,0);
    add(0,3,0,0,0, 100,0,0,0,0,1,0);
    add(0,0,0,0,0, 100,0,0,0,0,0,0);
    add(0,0,0,0,1, 100,0,0,1,3,0,0);
    add(0,0,0,0,0,  75,0,0,1,3,0,0);
    add(0,0,0,0,0,  50,0,0,1,3,0,0);
    add(0,0,0,0,0,  25,0,0,1,3,0,0);
    add(0,0,0,0,0,   0,0,0,0,0,0,0);
    // held coin counts once, insufficient credit denied
    add(0,2,0,0,0,  10,0,0,0,0,0,0);
    add(0,2,0,0,0,  10,0,0,0,0,0,0);
    add(0,2,0,0,0,  10,0,0,0,0,0,0);
    add(0,0,0,0,0,  10,0,0,0,0,0,0);
    add(0,1,0,0,0,  15,0,0,0,0,0,0);
    add(0,0,0,1,0,  15,0,0,0,0,0,1);
    add(0,1,0,0,0,  20,0,0,0,0,0,0);
    add(0,0,0,1,0,   0,1,0,0,0,0,0);
    add(0,0,0,0,0,   0,0,0,0,0,0,0);
    // highest product (35) exact, coin during DISPENSE returned
    add(0,3,0,0,0,  25,0,0,0,0,0,0);
    add(0,0,0,0,0,  25,0,0,0,0,0,0);
    add(0,2,0,0,0,  35,0,0,0,0,0,0);
    add(0,0,3,1,0,   0,1,3,0,0,0,0);
    add(0,1,0,0,0,   0,0,0,0,0,1,0);
    add(0,0,0,0,0,   0,0,0,0,0,0,0);
    // coin together with an accepted selection is returned
    add(0,2,0,0,0,  10,0,0,0,0,0,0);
    add(0,0,0,0,0,  10,0,0,0,0,0,0);
    add(0,2,0,0,0,  20,0,0,0,0,0,0);
    add(0,0,0,0,0,  20,0,0,0,0,0,0);
    add(0,1,0,1,0,   0,1,0,0,0,1,0);
    add(0,0,0,0,0,   0,0,0,0,0,0,0);
    // reset on the first CHANGE cycle abandons the refund
    add(0,3,0,0,0,  25,0,0,0,0,0,0);
    add(0,0,0,0,0,  25,0,0,0,0,0,0);
    add(0,2,0,0,0,  35,0,0,0,0,0,0);
    add(0,0,0,0,1,  35,0,0,1,3,0,0);
    add(1,0,0,0,0,   0,0,0,0,0,0,0);
    add(0,0,0,0,0,   0,0,0,0,0,0,0);
    add(0,0,0,0,0,   0,0,0,0,0,0,0);
    // deny in IDLE with zero credit, cancel in IDLE does nothing
    add(0,0,0,1,0,   0,0,0,0,0,0,1);
    add(0,0,0,0,0,   0,0,0,0,0,0,0);
    add(0,0,0,0,1,   0,0,0,0,0,0,0);
    add(0,0,0,0,0,   0,0,0,0,0,0,0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].coin, vecs[i].sel, vecs[i].sv, vecs[i].cancel);
      chk("credit", i, int'(credit), vecs[i].credit);
      chk("dispense", i, int'(dispense), vecs[i].disp);
      chk("disp_id", i, int'(disp_id), vecs[i].id);
      chk("change_valid", i, int'(change_valid), vecs[i].cv);
      chk("change_coin", i, int'(change_coin), vecs[i].cc);
      chk("coin_reject", i, int'(coin_reject), vecs[i].rej);
      chk("deny", i, int'(deny), vecs[i].deny);
    end

    // 25+10 buys product 0 -> refund 15 as 10,5
    buy_refund(3, 2, 0, 0, 0, 0, 1);
    // 25+25+25+10+10 buys product 0 -> refund 75 as 3x25
    buy_refund(3, 3, 3, 2, 2, 0, 2);
    // 25+25+5 buys product 2 (30) -> refund 25
    buy_refund(3, 3, 1, 0, 0, 2, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
